// File: rtl/tron_pkg.sv
// Shared definitions for the trail frame-buffer arbiter: screen geometry,
// address type, arbiter FSM states and player id.
package tron_pkg;

  localparam int unsigned LARGURA = 640;
  localparam int unsigned ALTURA  = 480;
  localparam int unsigned ADDR_W  = 19;

  typedef logic [ADDR_W-1:0] endereco_t;

  localparam endereco_t TOTAL_PIXELS = endereco_t'(LARGURA * ALTURA);

  typedef enum logic [2:0] {
    OCIOSO,
    LE,
    ESPERA,
    DECIDE,
    ESCREVE,
    CONCLUI,
    LIMPA
  } estado_t;

  typedef logic jogador_t;
  localparam jogador_t JOGADOR1 = 1'b0;
  localparam jogador_t JOGADOR2 = 1'b1;

  function automatic logic fora_da_tela(input endereco_t addr, input endereco_t total);
    return addr >= total;
  endfunction

endpackage

// File: rtl/varredura_limpeza.sv
// Clear-scan generator: linear address 0..LARGURA*ALTURA-1 and write data.
// With ARBITRO_RAM_BORDA_EN, x/y counters colour the screen border.
module varredura_limpeza #(
  parameter int unsigned LARGURA = tron_pkg::LARGURA,
  parameter int unsigned ALTURA  = tron_pkg::ALTURA
`ifdef ARBITRO_RAM_BORDA_EN
  ,
  parameter logic [7:0]  COR_BORDA = 8'hE0,
  parameter int unsigned MARGEM    = 16
`endif
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        avanca,
  output logic [tron_pkg::ADDR_W-1:0] addr,
  output logic [7:0]                  dado,
  output logic                        fim
);
  import tron_pkg::*;

  localparam endereco_t ULTIMO = endereco_t'(LARGURA * ALTURA - 1);

  endereco_t r_addr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr <= '0;
    end else if (start) begin
      r_addr <= '0;
    end else if (avanca) begin
      r_addr <= r_addr + endereco_t'(1);
    end
  end

  assign addr = r_addr;
  assign fim  = (r_addr == ULTIMO);

`ifdef ARBITRO_RAM_BORDA_EN
  localparam int unsigned X_W = $clog2(LARGURA);
  localparam int unsigned Y_W = $clog2(ALTURA) + 1;
  localparam logic [X_W-1:0] X_FIM = X_W'(LARGURA - 1);
  localparam logic [X_W-1:0] X_MIN = X_W'(MARGEM);
  localparam logic [X_W-1:0] X_MAX = X_W'(LARGURA - MARGEM);
  localparam logic [Y_W-1:0] Y_MIN = Y_W'(MARGEM);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(ALTURA - MARGEM);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_borda;

  // x/y follow the linear address so no divide is needed to locate the pixel
  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (avanca) begin
      if (r_x == X_FIM) begin
        r_x <= '0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign w_borda = (r_x < X_MIN) || (r_x >= X_MAX) || (r_y < Y_MIN) || (r_y >= Y_MAX);
  assign dado    = w_borda ? COR_BORDA : '0;
`else
  assign dado = '0;
`endif

endmodule

// File: rtl/arbitro_ram.sv
// Port-A arbiter for the trail frame buffer: atomic read-check-write per player
// move, round-robin on ties, and full-screen clear (border via ARBITRO_RAM_BORDA_EN).
module arbitro_ram #(
  parameter int unsigned LARGURA     = tron_pkg::LARGURA,
  parameter int unsigned ALTURA      = tron_pkg::ALTURA,
  parameter int unsigned LAT_LEITURA = 2
`ifdef ARBITRO_RAM_BORDA_EN
  ,
  parameter logic [7:0]  COR_BORDA   = 8'hE0,
  parameter int unsigned MARGEM      = 16
`endif
) (
  input  logic                        VGA_CLK,
  input  logic                        reset_n,
  input  logic                        limpar,
  input  logic                        req1,
  input  logic [tron_pkg::ADDR_W-1:0] addr1,
  input  logic [7:0]                  cor1,
  input  logic                        req2,
  input  logic [tron_pkg::ADDR_W-1:0] addr2,
  input  logic [7:0]                  cor2,
  output logic                        ack1,
  output logic                        ack2,
  output logic                        colisao1,
  output logic                        colisao2,
  output logic                        ocupado,
  output logic [tron_pkg::ADDR_W-1:0] ram_addr,
  output logic [7:0]                  ram_data,
  output logic                        ram_wren,
  input  logic [7:0]                  ram_q
);
  import tron_pkg::*;

  localparam endereco_t  TOTAL      = endereco_t'(LARGURA * ALTURA);
  localparam logic [1:0] ESPERA_INI = 2'(LAT_LEITURA - 2);

  estado_t   r_estado, w_prox;
  endereco_t r_addr;
  logic [7:0] r_cor;
  jogador_t  r_id, r_ultimo, w_vez;
  logic      r_col1, r_col2;
  logic [1:0] r_espera;
  logic      w_fora, w_marca;
  logic      w_lim_start, w_lim_avanca, w_lim_fim;
  endereco_t w_lim_addr;
  logic [7:0] w_lim_dado;

  varredura_limpeza #(
    .LARGURA   (LARGURA),
    .ALTURA    (ALTURA)
`ifdef ARBITRO_RAM_BORDA_EN
    ,
    .COR_BORDA (COR_BORDA),
    .MARGEM    (MARGEM)
`endif
  ) u_varredura (
    .clk     (VGA_CLK),
    .reset_n (reset_n),
    .start   (w_lim_start),
    .avanca  (w_lim_avanca),
    .addr    (w_lim_addr),
    .dado    (w_lim_dado),
    .fim     (w_lim_fim)
  );

  assign w_fora       = fora_da_tela(r_addr, TOTAL);
  assign w_lim_start  = (r_estado == OCIOSO) && limpar;
  assign w_lim_avanca = (r_estado == LIMPA);
  assign w_marca      = ((r_estado == LE) && w_fora) ||
                        ((r_estado == DECIDE) && (ram_q != '0));

  // Tie goes to whoever was not served last
  always_comb begin
    w_vez = JOGADOR1;
    if (req1 && req2) begin
      w_vez = (r_ultimo == JOGADOR1) ? JOGADOR2 : JOGADOR1;
    end else if (req2) begin
      w_vez = JOGADOR2;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (limpar) begin
          w_prox = LIMPA;
        end else if (req1 || req2) begin
          w_prox = LE;
        end
      end
      LE:      w_prox = w_fora ? CONCLUI : ESPERA;
      ESPERA:  w_prox = (r_espera == '0) ? DECIDE : ESPERA;
      DECIDE:  w_prox = (ram_q != '0) ? CONCLUI : ESCREVE;
      ESCREVE: w_prox = CONCLUI;
      CONCLUI: w_prox = OCIOSO;
      LIMPA:   w_prox = w_lim_fim ? OCIOSO : LIMPA;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_cor    <= '0;
      r_id     <= JOGADOR1;
      r_ultimo <= JOGADOR2;
      r_col1   <= 1'b0;
      r_col2   <= 1'b0;
      r_espera <= '0;
    end else begin
      if (r_estado == OCIOSO && !limpar && (req1 || req2)) begin
        r_id   <= w_vez;
        r_addr <= (w_vez == JOGADOR2) ? addr2 : addr1;
        r_cor  <= (w_vez == JOGADOR2) ? cor2 : cor1;
      end
      if (r_estado == OCIOSO && limpar) begin
        r_col1 <= 1'b0;
        r_col2 <= 1'b0;
      end else if (w_marca) begin
        if (r_id == JOGADOR2) begin
          r_col2 <= 1'b1;
        end else begin
          r_col1 <= 1'b1;
        end
      end
      if (r_estado == LE) begin
        r_espera <= ESPERA_INI;
      end else if (r_estado == ESPERA && r_espera != '0) begin
        r_espera <= r_espera - 2'd1;
      end
      if (r_estado == CONCLUI) begin
        r_ultimo <= r_id;
      end
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    ack1     = 1'b0;
    ack2     = 1'b0;
    case (r_estado)
      LE:             ram_addr = w_fora ? '0 : r_addr;
      ESPERA, DECIDE: ram_addr = r_addr;
      ESCREVE: begin
        ram_addr = r_addr;
        ram_data = r_cor;
        ram_wren = 1'b1;
      end
      CONCLUI: begin
        ack1 = (r_id == JOGADOR1);
        ack2 = (r_id == JOGADOR2);
      end
      LIMPA: begin
        ram_addr = w_lim_addr;
        ram_data = w_lim_dado;
        ram_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign ocupado  = (r_estado != OCIOSO);
  assign colisao1 = r_col1;
  assign colisao2 = r_col2;

endmodule

// File: tb/tb_arbitro_ram.sv
// Randomized scoreboard bench for arbitro_ram on a reduced 64x48 screen with a
// latency-2 RAM model; expected results come from a pixel-occupancy reference.
module tb_arbitro_ram;

  localparam int unsigned L   = 64;
  localparam int unsigned A   = 48;
  localparam int unsigned TOT = L * A;

  logic        VGA_CLK = 1'b0;
  logic        reset_n, limpar, req1, req2;
  logic [18:0] addr1, addr2;
  logic [7:0]  cor1, cor2;
  logic        ack1, ack2, colisao1, colisao2, ocupado, ram_wren;
  logic [18:0] ram_addr;
  logic [7:0]  ram_data, ram_q;

  always #5 VGA_CLK = ~VGA_CLK;

  arbitro_ram #(
    .LARGURA     (L),
    .ALTURA      (A),
    .LAT_LEITURA (2)
`ifdef ARBITRO_RAM_BORDA_EN
    ,
    .COR_BORDA   (8'hE0),
    .MARGEM      (16)
`endif
  ) dut (
    .VGA_CLK  (VGA_CLK),
    .reset_n  (reset_n),
    .limpar   (limpar),
    .req1     (req1),
    .addr1    (addr1),
    .cor1     (cor1),
    .req2     (req2),
    .addr2    (addr2),
    .cor2     (cor2),
    .ack1     (ack1),
    .ack2     (ack2),
    .colisao1 (colisao1),
    .colisao2 (colisao2),
    .ocupado  (ocupado),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  // RAM with 2-cycle read latency: registered address, registered data
  logic [7:0]  mem [TOT];
  logic [18:0] r_a;
  logic        ram_init;

  always @(posedge VGA_CLK) begin
    if (ram_init) begin
      for (int i = 0; i < int'(TOT); i++) mem[i] <= '0;
    end else if (ram_wren && ram_addr < TOT) begin
      mem[ram_addr] <= ram_data;
    end
    r_a   <= ram_addr;
    ram_q <= (r_a < TOT) ? mem[r_a] : 8'h00;
  end

  typedef struct {
    int          jog;
    bit          esc;
    int unsigned addr;
    logic [7:0]  dado;
    bit          c1;
    bit          c2;
  } esp_t;

  esp_t        fila[$];
  logic [7:0]  ref_mem [TOT];
  bit          ref_c1, ref_c2;
  int          ultimo;
  bit          em_limpeza;
  int          n_comp, n_erros;

  task automatic confere(input string nome, input longint atual, input longint esperado);
    n_comp++;
    if (atual != esperado) begin
      n_erros++;
      $display("FAIL %s: obtido=%0h esperado=%0h t=%0t", nome, atual, esperado, $time);
    end
  endtask

  function automatic logic [7:0] esperado_limpa(input int unsigned a);
`ifdef ARBITRO_RAM_BORDA_EN
    int unsigned x = a % L;
    int unsigned y = a / L;
    if (x < 16 || x >= L - 16 || y < 16 || y >= A - 16) return 8'hE0;
`endif
    return 8'h00;
  endfunction

  // Reference: a free in-range pixel takes the colour, anything else is a collision
  task automatic modelo(input int p, input int unsigned a, input logic [7:0] c, output int lat);
    esp_t e;
    e.jog  = p;
    e.addr = a;
    e.dado = c;
    if (a < TOT && ref_mem[a] == 8'h00) begin
      e.esc     = 1'b1;
      ref_mem[a] = c;
      lat       = 5;
    end else begin
      e.esc = 1'b0;
      if (p == 1) ref_c1 = 1'b1;
      else        ref_c2 = 1'b1;
      lat = (a < TOT) ? 4 : 2;
    end
    e.c1   = ref_c1;
    e.c2   = ref_c2;
    ultimo = p;
    fila.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every ack
  int          n_esc, n_fora;
  logic [18:0] ult_a;
  logic [7:0]  ult_d;

  always @(negedge VGA_CLK) begin
    if (reset_n) begin
      if (ram_wren && !em_limpeza) begin
        n_esc++;
        ult_a = ram_addr;
        ult_d = ram_data;
      end
      if (ram_addr >= TOT) n_fora++;
      if (ack1 || ack2) begin
        if (fila.size() == 0) begin
          confere("ack_inesperado", {ack1, ack2}, 0);
        end else begin
          esp_t e;
          int   jog;
          e   = fila.pop_front();
          jog = (ack1 && ack2) ? 3 : (ack1 ? 1 : 2);
          confere("jogador_servido", jog, e.jog);
          if (e.esc) begin
            confere("escrita_unica", n_esc, 1);
            confere("escrita_addr", ult_a, e.addr);
            confere("escrita_dado", ult_d, e.dado);
          end else begin
            confere("sem_escrita", n_esc, 0);
          end
          confere("colisao", {colisao1, colisao2}, {e.c1, e.c2});
          confere("sem_acesso_fora", n_fora, 0);
        end
        n_esc  = 0;
        n_fora = 0;
      end
    end
  end

  task automatic espera_acks(input bit e1, input bit e2, input int lat_esp);
    bit g1  = !e1;
    bit g2  = !e2;
    int n   = 0;
    int lat = -1;
    while (!(g1 && g2) && n < 60) begin
      @(negedge VGA_CLK);
      n++;
      if (ack1 && !g1) begin g1 = 1'b1; req1 = 1'b0; if (lat < 0) lat = n; end
      if (ack2 && !g2) begin g2 = 1'b1; req2 = 1'b0; if (lat < 0) lat = n; end
    end
    if (!(g1 && g2)) begin
      confere("ack_timeout", {g1, g2}, 3);
      req1 = 1'b0;
      req2 = 1'b0;
    end else if (lat_esp >= 0) begin
      confere("latencia_ack", lat, lat_esp);
    end
    @(negedge VGA_CLK);
  endtask

  task automatic pedido(input bit p1, input bit p2, input int unsigned a1, input int unsigned a2,
                        input logic [7:0] c1, input logic [7:0] c2);
    int l1 = 0, l2 = 0, prim;
    if (p1 && p2) prim = (ultimo == 1) ? 2 : 1;
    else          prim = p1 ? 1 : 2;
    if (prim == 1) begin
      modelo(1, a1, c1, l1);
      if (p2) modelo(2, a2, c2, l2);
    end else begin
      modelo(2, a2, c2, l2);
      if (p1) modelo(1, a1, c1, l1);
    end
    addr1 = 19'(a1); cor1 = c1; req1 = p1;
    addr2 = 19'(a2); cor2 = c2; req2 = p2;
    espera_acks(p1, p2, (prim == 1) ? l1 : l2);
  endtask

  task automatic confere_zerado(input string nome);
    confere(nome, {ocupado, ack1, ack2, colisao1, colisao2, ram_wren, ram_addr, ram_data}, 0);
  endtask

  task automatic pulso_reset();
    reset_n = 1'b0;
    @(negedge VGA_CLK);
    confere_zerado("reset_saidas");
    reset_n = 1'b1;
    ref_c1  = 1'b0;
    ref_c2  = 1'b0;
    ultimo  = 2;
    @(negedge VGA_CLK);
  endtask

  // Full clear when corte >= TOT, otherwise reset is asserted while writing address corte
  task automatic limpeza(input int unsigned corte, input bit pedir, input int unsigned a_req);
    int bad = 0;
    int lat = -1;
    em_limpeza = 1'b1;
    limpar     = 1'b1;
    ref_c1     = 1'b0;
    ref_c2     = 1'b0;
    if (corte >= TOT) begin
      for (int unsigned j = 0; j < TOT; j++) ref_mem[j] = esperado_limpa(j);
    end
    for (int unsigned k = 0; k < TOT; k++) begin
      @(negedge VGA_CLK);
      if (k == 0) limpar = 1'b0;
      if (!(ram_wren && ram_addr == k && ram_data == esperado_limpa(k) && ocupado && !ack1 && !ack2)) begin
        if (bad == 0) $display("FAIL limpa_ciclo: k=%0d wren=%0b addr=%0d dado=%0h ocupado=%0b", k, ram_wren, ram_addr, ram_data, ocupado);
        bad++;
      end
      if (pedir && k == 100) begin
        modelo(1, a_req, 8'h5A, lat);
        addr1 = 19'(a_req); cor1 = 8'h5A; req1 = 1'b1;
      end
      if (k == corte) begin
        for (int unsigned j = 0; j <= k; j++) ref_mem[j] = esperado_limpa(j);
        reset_n = 1'b0;
        @(negedge VGA_CLK);
        confere("abort_wren", ram_wren, 0);
        confere("abort_ocupado", ocupado, 0);
        confere("abort_saidas", {ack1, ack2, colisao1, colisao2}, 0);
        confere("abort_escritas_ok", bad, 0);
        reset_n    = 1'b1;
        ultimo     = 2;
        em_limpeza = 1'b0;
        @(negedge VGA_CLK);
        return;
      end
    end
    @(negedge VGA_CLK);
    confere("limpa_escritas_ok", bad, 0);
    confere("limpa_fim_ocupado", ocupado, 0);
    confere("limpa_flags", {colisao1, colisao2}, 0);
    em_limpeza = 1'b0;
    if (pedir) espera_acks(1'b1, 1'b0, lat);
  endtask

  function automatic int unsigned addr_aleat();
    int unsigned r = $urandom_range(0, 15);
    if (r == 0) return TOT + $urandom_range(0, 3);
    if (r == 1) return 19'h7FFFF;
    if (r <= 4) return $urandom_range(0, TOT - 1);
    return 1040 + $urandom_range(0, 31);
  endfunction

  task automatic aleatorio(input int n);
    repeat (n) begin
      int unsigned m = $urandom_range(0, 2);
      pedido(m != 1, m != 0, addr_aleat(), addr_aleat(),
             8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int l;
    n_comp = 0; n_erros = 0; n_esc = 0; n_fora = 0;
    em_limpeza = 1'b0;
    reset_n = 1'b0; ram_init = 1'b1; limpar = 1'b0;
    req1 = 1'b0; req2 = 1'b0; addr1 = '0; addr2 = '0; cor1 = '0; cor2 = '0;
    for (int unsigned j = 0; j < TOT; j++) ref_mem[j] = 8'h00;
    ref_c1 = 1'b0; ref_c2 = 1'b0; ultimo = 2;
    repeat (2) @(negedge VGA_CLK);
    ram_init = 1'b0;
    pulso_reset();

    pedido(1'b1, 1'b0, 1000, 0, 8'hFF, 8'h00);
    pedido(1'b1, 1'b0, 1000, 0, 8'h33, 8'h00);
    confere("colisao1_pegajosa", colisao1, 1);

    pulso_reset();
    pedido(1'b1, 1'b1, 10, 20, 8'hAA, 8'hBB);
    pedido(1'b1, 1'b0, 30, 0, 8'h11, 8'h00);
    pedido(1'b1, 1'b1, 11, 21, 8'h12, 8'h22);
    pedido(1'b0, 1'b1, 0, TOT, 8'h00, 8'h44);

    modelo(2, 40, 8'h66, l);
    addr2 = 19'd40; cor2 = 8'h66; req2 = 1'b1;
    @(negedge VGA_CLK);
    req2 = 1'b0;
    espera_acks(1'b0, 1'b1, l - 1);

    aleatorio(60);
    limpeza(TOT, 1'b1, 1050);
    aleatorio(40);
    limpeza(2000, 1'b0, 0);
    pedido(1'b1, 1'b1, 1041, 1041, 8'h01, 8'h02);
    aleatorio(30);

    confere("fila_vazia", fila.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erros);
    $finish;
  end

endmodule

// File: doc/arbitro_ram.md
Name: arbitro_ram

Overview:
- Shares the single write/read port (port A) of the 640x480 8-bit trail frame buffer between the two players.
- Each player move request becomes an atomic read-check-write: read the target pixel; if it is free, write the player colour, otherwise report a collision.
- Also sequences the full-screen clear on game restart.
- Sits between `jogador1`/`jogador2` and the `ram` instance. The VGA scanout keeps port B.

Parameters:
- `LARGURA`, 640, screen width in pixels.
- `ALTURA`, 480, screen height in pixels.
- `LAT_LEITURA`, 2, cycles from `ram_addr` valid to `ram_q` valid (2 or 3).
- `COR_BORDA`, 8'hE0, border colour written during clear (optional feature only).
- `MARGEM`, 16, border thickness in pixels (optional feature only).

Ports:
- `VGA_CLK`  in  1  single clock for the block.
- `reset_n`  in  1  synchronous, active-low reset.
- `limpar`  in  1  level; start a full-screen clear. Sampled only in `OCIOSO`.
- `req1`  in  1  player 1 move request; held until `ack1`.
- `addr1`  in  19  player 1 target pixel address (`x + y*LARGURA`).
- `cor1`  in  8  player 1 trail colour.
- `req2`  in  1  player 2 move request.
- `addr2`  in  19  player 2 target pixel address.
- `cor2`  in  8  player 2 trail colour.
- `ack1`  out  1  one-cycle pulse: player 1 request complete.
- `ack2`  out  1  one-cycle pulse: player 2 request complete.
- `colisao1`  out  1  sticky flag: player 1 hit a used or out-of-range pixel.
- `colisao2`  out  1  sticky flag: player 2 hit a used or out-of-range pixel.
- `ocupado`  out  1  high in every state except `OCIOSO`.
- `ram_addr`  out  19  RAM port A address.
- `ram_data`  out  8  RAM port A write data.
- `ram_wren`  out  1  RAM port A write enable.
- `ram_q`  in  8  RAM port A read data.

Behaviour:
- Reset (`reset_n`=0 at a clock edge):
  - State goes to `OCIOSO`; all outputs are 0.
  - The round-robin pointer is reset to favour player 1.
  - Reset aborts any operation, including a clear in progress.
- FSM states: `OCIOSO`, `LE`, `ESPERA`, `DECIDE`, `ESCREVE`, `CONCLUI`, `LIMPA`.
- `OCIOSO` priority: `limpar` first, then player requests.
  - `limpar`=1: clear `colisao1`/`colisao2`, clear-address counter := 0, go to `LIMPA`.
  - Otherwise, if any `req` is high, grant one player and latch its address, colour and id. Go to `LE`.
  - Both `req` high in the same cycle: grant the player not granted last (round robin). After reset, player 1 wins.
- `LE`: drive the latched address on `ram_addr` with `ram_wren`=0; go to `ESPERA`.
  - If the address is ≥ `LARGURA*ALTURA` (307200), skip the read: flag a collision and go straight to `CONCLUI`.
- `ESPERA`: hold the address for `LAT_LEITURA`-1 cycles, then go to `DECIDE`.
- `DECIDE`: sample `ram_q`.
  - `ram_q` != 0: set the granted player's `colisao` flag; go to `CONCLUI` with no write.
  - `ram_q` == 0: go to `ESCREVE`.
- `ESCREVE`: exactly one cycle with `ram_wren`=1, `ram_data` = latched colour, `ram_addr` = latched address; go to `CONCLUI`.
- `CONCLUI`: pulse the granted player's `ack` for one cycle, update the round-robin pointer, go to `OCIOSO`.
- Latency: an uncontested legal request is acked at cycle `LAT_LEITURA`+3 after the grant cycle (5 with `LAT_LEITURA`=2). A collision acks one cycle earlier.
- `LIMPA`: one write per cycle.
  - `ram_wren`=1, `ram_addr` = counter, `ram_data` = 0 (or the border colour, see Optional Feature).
  - The counter runs from 0 to 307199 (307200 cycles). After the last write, return to `OCIOSO`.
  - Requests are not granted during a clear; they stay pending.
- Collision flags are sticky until the next clear or reset. Requests from a collided player are still served.
- A request dropped before its ack is still completed; the ack is pulsed anyway.
- `ram_wren` is 0 in every state except `ESCREVE` and `LIMPA`.
- Address arithmetic is 19-bit unsigned. The counter compare uses a full 19-bit constant.

Optional Feature:
- Macro: `ARBITRO_RAM_BORDA_EN`.
- Defined: during `LIMPA`, pixels with x < `MARGEM`, x ≥ `LARGURA`-`MARGEM`, y < `MARGEM` or y ≥ `ALTURA`-`MARGEM` are written with `COR_BORDA`; all others with 0.
  - The border therefore becomes a collision source.
  - x and y are tracked as separate counters stepped alongside the linear address; no divider.
- Not defined: `LIMPA` writes 0 everywhere, and only out-of-range addresses count as wall collisions.

Decomposition:
- Shared package `tron_pkg`:
  - FSM state encoding.
  - `LARGURA`, `ALTURA`, `TOTAL_PIXELS` (= 307200).
  - Address width 19.
  - Player id type (1 bit).
- One natural sub-module: `varredura_limpeza`.
  - Contents: the clear address counter and x/y border generator.
  - Interface: `start`, `addr`, `dado`, `fim`.

Test Plan:
1. Reset, then `req1` with `addr1`=1000, `cor1`=8'hFF; RAM holds 0 → one `ram_wren` pulse at addr 1000 data FF; `ack1` at cycle 5; `colisao1`=0.
2. Repeat `req1` with `addr1`=1000 → no `ram_wren`; `ack1` pulsed; `colisao1`=1 and stays 1.
3. `req1` and `req2` in the same cycle at addresses 10 and 20 → player 1 served first (ack at cycle 5), player 2 next; following tie goes to player 2 first.
4. `req2` with `addr2`=307200 → no RAM read or write; `ack2` pulsed; `colisao2`=1.
5. `limpar` pulse → `ocupado` high for exactly 307200 write cycles, address 0 to 307199; both collision flags cleared; a `req1` raised mid-clear is acked only after the clear. With `ARBITRO_RAM_BORDA_EN`: addr 0 written E0, addr 16*640+16 written 0.
6. `reset_n` low mid-clear at address 5000 → next cycle `ram_wren`=0, state `OCIOSO`, `ocupado`=0.
